// File: rtl/updi_uart_rx.sv
// updi_uart_rx: UPDI serial receiver; deframes start/data/parity/stop, flags parity/framing errors and BREAK.
// Ports: clk/rst (sync, active-high); rx raw idle-high line; data/valid/ready character handshake;
// parity_err/frame_err per-character flags; overrun sticky drop flag; busy = FSM not idle.
module updi_uart_rx #(
  parameter int    CLK_DIV   = 16,
  parameter int    BITS      = 8,
  parameter string PARITY    = "even",
  parameter int    STOP_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [BITS-1:0] data,
  output logic            valid,
  input  logic            ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(BITS + 1);
  localparam bit HAS_PAR = PARITY != "none";
  localparam bit ODD = PARITY == "odd";
  // Start-bit sample lands CLK_DIV/2 cycles after rx_s falls; one cycle is spent detecting the edge.
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 2);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(BITS - 1);
  localparam logic [DW-1:0] SLAST = DW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE, WAIT_HIGH} state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s, rx_p;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dcnt;
  logic [BITS-1:0] sh;
  logic            pe, fe;
  logic            fall, tick, dlast, slast, par_exp, load;

  assign fall    = rx_p && !rx_s;
  assign tick    = cnt == '0;
  assign dlast   = dcnt == DLAST;
  assign slast   = dcnt == SLAST;
  assign par_exp = ODD ^ (^sh);
  // A completing frame may load whenever the holding register is empty or being drained this cycle.
  assign load    = state == DONE && (!valid || ready);

  always_ff @(posedge clk)
    if (rst) {rx_m, rx_s, rx_p} <= 3'b111;
    else     {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};

  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = fall ? START : IDLE;
      START:     if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:      if (tick && dlast) state_n = HAS_PAR ? PAR : STOP;
      PAR:       if (tick) state_n = STOP;
      STOP:      if (tick && slast) state_n = DONE;
      // A BREAK keeps the line low past the frame; wait it out so it yields a single character.
      DONE:      state_n = (fe && !rx_s) ? WAIT_HIGH : IDLE;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end

  always_comb busy = state != IDLE;

  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= '0;
      dcnt <= '0;
      sh   <= '0;
      pe   <= 1'b0;
      fe   <= 1'b0;
    end else begin
      cnt  <= state == IDLE ? HALF : tick ? FULL : cnt - 1'b1;
      dcnt <= state == IDLE ? '0 :
              ((state == DATA || state == STOP) && tick) ? (((state == DATA) ? dlast : slast) ? '0 : dcnt + 1'b1) :
              dcnt;
      sh   <= (state == DATA && tick) ? {rx_s, sh[BITS-1:1]} : sh;
      pe   <= state == IDLE ? 1'b0 : (state == PAR && tick) ? rx_s != par_exp : pe;
      fe   <= state == IDLE ? 1'b0 : (state == STOP && tick && !rx_s) ? 1'b1 : fe;
    end

  always_ff @(posedge clk)
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data       <= sh;
        parity_err <= pe;
        frame_err  <= fe;
      end
      valid   <= load || (valid && !ready);
      overrun <= overrun || (state == DONE && !load);
    end
endmodule

// File: tb/tb_updi_uart_rx.sv
// tb_updi_uart_rx: directed bench for updi_uart_rx (8E2 and 8O2 instances, CLK_DIV=16).
module tb_updi_uart_rx;
  localparam int D = 16;
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [7:0] data_e, data_o;
  logic       valid_e, pe_e, fe_e, ov_e, busy_e;
  logic       valid_o, pe_o, fe_o, ov_o, busy_o;
  int         tests = 0, fails = 0, cyc = 0, first_v = -1, nval = 0, rst_at = -1;
  logic       prev_v = 1'b0;

  always #5 clk = ~clk;

  updi_uart_rx #(.CLK_DIV(D), .BITS(8), .PARITY("even"), .STOP_BITS(2)) u_even (
    .clk(clk), .rst(rst), .rx(rx), .data(data_e), .valid(valid_e), .ready(ready),
    .parity_err(pe_e), .frame_err(fe_e), .overrun(ov_e), .busy(busy_e));

  updi_uart_rx #(.CLK_DIV(D), .BITS(8), .PARITY("odd"), .STOP_BITS(2)) u_odd (
    .clk(clk), .rst(rst), .rx(rx), .data(data_o), .valid(valid_o), .ready(ready),
    .parity_err(pe_o), .frame_err(fe_o), .overrun(ov_o), .busy(busy_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (valid_e && !prev_v) begin
      nval++;
      if (first_v < 0) first_v = cyc;
    end
    prev_v = valid_e;
    rst = rst_at >= 0 && cyc == rst_at - 1;
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s, input int idle_bits);
    cyc = 0;
    first_v = -1;
    nval = 0;
    hold(1'b0, D);
    for (int i = 0; i < 8; i++) hold(d[i], D);
    hold(p, D);
    hold(s, D);
    hold(s, D);
    hold(1'b1, idle_bits * D);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_e, 8'h00);
    chk("rst_valid", valid_e, 1'b0);
    chk("rst_perr", pe_e, 1'b0);
    chk("rst_ferr", fe_e, 1'b0);
    chk("rst_overrun", ov_e, 1'b0);
    chk("rst_busy", busy_e, 1'b0);
    rst = 1'b0;
    hold(1'b1, 4);

    send(8'h55, 1'b0, 1'b1, 2);
    chk("lat_55", first_v, 187);
    chk("cnt_55", nval, 1);
    chk("data_55", data_e, 8'h55);
    chk("perr_55", pe_e, 1'b0);
    chk("ferr_55", fe_e, 1'b0);
    chk("valid_drop_55", valid_e, 1'b0);

    send(8'h07, 1'b0, 1'b1, 2);
    chk("data_07", data_e, 8'h07);
    chk("perr_07_even", pe_e, 1'b1);
    chk("ferr_07", fe_e, 1'b0);
    chk("data_07_odd", data_o, 8'h07);
    chk("perr_07_odd", pe_o, 1'b0);

    cyc = 0;
    nval = 0;
    hold(1'b0, 4);
    chk("glitch_busy_hi", busy_e, 1'b1);
    hold(1'b1, D / 2 + 3);
    chk("glitch_busy_lo", busy_e, 1'b0);
    chk("glitch_noval", nval, 0);

    cyc = 0;
    nval = 0;
    hold(1'b0, 24 * D);
    chk("break_wait_busy", busy_e, 1'b1);
    hold(1'b1, 2 * D);
    chk("break_cnt", nval, 1);
    chk("break_data", data_e, 8'h00);
    chk("break_perr", pe_e, 1'b0);
    chk("break_ferr", fe_e, 1'b1);
    chk("break_idle", busy_e, 1'b0);
    send(8'hA5, 1'b0, 1'b1, 2);
    chk("a5_cnt", nval, 1);
    chk("a5_data", data_e, 8'hA5);
    chk("a5_perr", pe_e, 1'b0);
    chk("a5_ferr", fe_e, 1'b0);

    send(8'h81, 1'b0, 1'b1, 1);
    chk("b2b_first_cnt", nval, 1);
    chk("b2b_first_data", data_e, 8'h81);
    send(8'h7E, 1'b0, 1'b1, 2);
    chk("b2b_second_cnt", nval, 1);
    chk("b2b_second_data", data_e, 8'h7E);

    ready = 1'b0;
    send(8'h11, 1'b0, 1'b1, 2);
    chk("ovr_valid1", valid_e, 1'b1);
    chk("ovr_data1", data_e, 8'h11);
    chk("ovr_flag1", ov_e, 1'b0);
    send(8'h22, 1'b0, 1'b1, 2);
    chk("ovr_valid2", valid_e, 1'b1);
    chk("ovr_data2", data_e, 8'h11);
    chk("ovr_flag2", ov_e, 1'b1);
    ready = 1'b1;
    nval = 0;
    step();
    chk("ovr_accept", valid_e, 1'b0);
    hold(1'b1, 3 * D);
    chk("ovr_no22", nval, 0);
    chk("ovr_data_kept", data_e, 8'h11);
    chk("ovr_sticky", ov_e, 1'b1);

    rst_at = 100;
    send(8'hE0, 1'b1, 1'b1, 2);
    rst_at = -1;
    chk("abort_noval", nval, 0);
    chk("abort_data", data_e, 8'h00);
    chk("abort_overrun", ov_e, 1'b0);
    chk("abort_busy", busy_e, 1'b0);
    send(8'h3C, 1'b0, 1'b1, 2);
    chk("3c_cnt", nval, 1);
    chk("3c_data", data_e, 8'h3C);
    chk("3c_perr", pe_e, 1'b0);
    chk("3c_ferr", fe_e, 1'b0);
    chk("3c_overrun", ov_e, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
